// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit queue.
// Holds the feeder FSM state enumeration and the default FIFO depth and
// busy-wait timeout used by uart_tx_queue and its interface.
package uart_pkg;

  localparam int unsigned DefaultDepth       = 16;
  localparam int unsigned DefaultBusyTimeout = 4;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWaitBusy,
    StWaitDone
  } feed_state_e;

endpackage

// File: rtl/uart_tx_queue_if.sv
// Bus interface of uart_tx_queue: enqueue side, status flags and the
// transmitter handshake. clk/rst remain plain ports on the modules.
//   slave  : seen by uart_tx_queue (push/clear/busy in, flags/strobe out)
//   master : seen by whoever drives pushes and models the transmitter
interface uart_tx_queue_if
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH = DefaultDepth
);

  logic                     push_i;
  logic [7:0]               push_data_i;
  logic                     ovf_clr_i;
  logic                     full_o;
  logic                     empty_o;
  logic [$clog2(DEPTH):0]   level_o;
  logic                     overflow_o;
  logic                     uart_wr_o;
  logic [7:0]               uart_dat_o;
  logic                     uart_busy_i;

  modport slave (
    input  push_i,
    input  push_data_i,
    input  ovf_clr_i,
    output full_o,
    output empty_o,
    output level_o,
    output overflow_o,
    output uart_wr_o,
    output uart_dat_o,
    input  uart_busy_i
  );

  modport master (
    output push_i,
    output push_data_i,
    output ovf_clr_i,
    input  full_o,
    input  empty_o,
    input  level_o,
    input  overflow_o,
    input  uart_wr_o,
    input  uart_dat_o,
    output uart_busy_i
  );

endinterface

// File: rtl/uart_fifo.sv
// Byte FIFO for the UART transmit queue.
// Ports:
//   clk, rst      : clock, asynchronous active-high reset
//   push_i        : enqueue push_data_i (ignored while full, even with a pop)
//   pop_i         : dequeue the head entry (ignored while empty)
//   rd_data_o     : head entry, valid while empty_o is low
//   full_o/empty_o/level_o : registered occupancy, updated at the push/pop edge
module uart_fifo #(
  parameter int unsigned DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push_i,
  input  logic [7:0]             push_data_i,
  input  logic                   pop_i,
  output logic [7:0]             rd_data_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] level_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          full_q, full_d;
  logic          empty_q, empty_d;
  logic          push_acc;
  logic          pop_acc;

  // A full FIFO drops the push outright; a same-cycle pop does not make room.
  assign push_acc = push_i & ~full_q;
  assign pop_acc  = pop_i & ~empty_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    // Pointers are AW bits wide, so increments wrap modulo DEPTH.
    if (push_acc) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop_acc)  rd_ptr_d = rd_ptr_q + AW'(1);
    level_d = level_q + LW'(push_acc) - LW'(pop_acc);
    full_d  = (level_d == LW'(DEPTH));
    empty_d = (level_d == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  // Storage needs no reset: entries are only read once the level covers them.
  always_ff @(posedge clk) begin
    if (push_acc) mem_q[wr_ptr_q] <= push_data_i;
  end

  assign rd_data_o = mem_q[rd_ptr_q];
  assign full_o    = full_q;
  assign empty_o   = empty_q;
  assign level_o   = level_q;

endmodule

// File: rtl/uart_tx_queue.sv
// UART transmit queue: buffers bytes in uart_fifo and feeds them one at a
// time to a UART transmitter using a write strobe / busy handshake.
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   bus      : uart_tx_queue_if.slave
//              push_i/push_data_i enqueue, ovf_clr_i clears overflow_o,
//              full_o/empty_o/level_o occupancy, overflow_o sticky drop flag,
//              uart_wr_o one-cycle strobe with uart_dat_o, uart_busy_i from
//              the transmitter.
module uart_tx_queue
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH        = DefaultDepth,
  parameter int unsigned BUSY_TIMEOUT = DefaultBusyTimeout
) (
  input  logic            clk,
  input  logic            rst,
  uart_tx_queue_if.slave  bus
);

  localparam int unsigned LW = $clog2(DEPTH) + 1;
  localparam int unsigned TW = (BUSY_TIMEOUT > 1) ? $clog2(BUSY_TIMEOUT) : 1;

  feed_state_e   state_q, state_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [7:0]    dat_q, dat_d;
  logic          ovf_q, ovf_d;
  logic          pop;
  logic [7:0]    head;
  logic          fifo_full;
  logic          fifo_empty;
  logic [LW-1:0] fifo_level;

  uart_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push_i     (bus.push_i),
    .push_data_i(bus.push_data_i),
    .pop_i      (pop),
    .rd_data_o  (head),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty),
    .level_o    (fifo_level)
  );

  // Feeder: the byte is popped when it is latched into dat_q, so a
  // transmitter that never acknowledges (timeout) loses that byte.
  always_comb begin
    state_d = state_q;
    tmo_d   = tmo_q;
    dat_d   = dat_q;
    pop     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!fifo_empty && !bus.uart_busy_i) begin
          state_d = StIssue;
          dat_d   = head;
          pop     = 1'b1;
        end
      end
      StIssue: begin
        state_d = StWaitBusy;
        tmo_d   = '0;
      end
      StWaitBusy: begin
        if (bus.uart_busy_i) begin
          state_d = StWaitDone;
        end else if (tmo_q == TW'(BUSY_TIMEOUT - 1)) begin
          state_d = StIdle;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      StWaitDone: begin
        if (!bus.uart_busy_i) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Set beats clear when an overflowing push meets ovf_clr_i.
  always_comb begin
    ovf_d = ovf_q;
    if (bus.push_i && fifo_full) begin
      ovf_d = 1'b1;
    end else if (bus.ovf_clr_i) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      tmo_q   <= '0;
      dat_q   <= 8'h00;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tmo_q   <= tmo_d;
      dat_q   <= dat_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.uart_wr_o  = (state_q == StIssue);
  assign bus.uart_dat_o = dat_q;
  assign bus.overflow_o = ovf_q;
  assign bus.full_o     = fifo_full;
  assign bus.empty_o    = fifo_empty;
  assign bus.level_o    = fifo_level;

endmodule

// File: doc/uart_tx_queue.md
UART_TX_QUEUE -- requirements
Module: uart_tx_queue

Interface
REQ-001 The block SHALL have parameter DEPTH, default 16, meaning FIFO entries (power of two, 2..256).
REQ-002 The block SHALL have parameter BUSY_TIMEOUT, default 4, meaning max cycles to wait for uart_busy_i to rise after a write strobe.
REQ-003 The block SHALL have port clk, input, 1, system clock.
REQ-004 The block SHALL have port rst, input, 1, reset (asynchronous, active-high).
REQ-005 The block SHALL have port push_i, input, 1, enqueue strobe, one byte per cycle.
REQ-006 The block SHALL have port push_data_i, input, 8, byte to enqueue.
REQ-007 The block SHALL have port ovf_clr_i, input, 1, clears the sticky overflow flag.
REQ-008 The block SHALL have port full_o, output, 1, high when level equals DEPTH.
REQ-009 The block SHALL have port empty_o, output, 1, high when level equals 0.
REQ-010 The block SHALL have port level_o, output, clog2(DEPTH)+1, current entry count.
REQ-011 The block SHALL have port overflow_o, output, 1, sticky flag set by a push while full.
REQ-012 The block SHALL have port uart_wr_o, output, 1, one-cycle write strobe to the transmitter.
REQ-013 The block SHALL have port uart_dat_o, output, 8, byte presented with uart_wr_o, held stable until the next strobe.
REQ-014 The block SHALL have port uart_busy_i, input, 1, transmitter busy flag.

Function
REQ-015 The FIFO SHALL accept push_i when not full, writing at the write pointer; pointers SHALL wrap modulo DEPTH.
REQ-016 A push while full SHALL be dropped, even with a same-cycle pop, and SHALL set overflow_o the following cycle.
REQ-017 overflow_o SHALL stay high until ovf_clr_i; if ovf_clr_i and an overflowing push coincide, set SHALL win.
REQ-018 Simultaneous push and pop when not full SHALL leave level unchanged.
REQ-019 level_o, full_o and empty_o SHALL be registered and SHALL reflect pushes and pops one cycle after the edge at which they occur.
REQ-020 The feeder FSM SHALL have the states IDLE, ISSUE, WAIT_BUSY and WAIT_DONE.
REQ-021 IDLE SHALL go to ISSUE when empty_o is low and uart_busy_i is low; on that edge the head byte SHALL load into uart_dat_o and be popped.
REQ-022 In ISSUE, uart_wr_o SHALL be high for exactly one cycle, then the FSM SHALL go to WAIT_BUSY.
REQ-023 WAIT_BUSY SHALL go to WAIT_DONE when uart_busy_i is high, or to IDLE after BUSY_TIMEOUT cycles without it; a timeout SHALL drop the byte and not retry.
REQ-024 WAIT_DONE SHALL go to IDLE when uart_busy_i is low.
REQ-025 First-byte latency SHALL be exactly: push at edge N into an empty FIFO, uart_wr_o high during cycle N+2.
REQ-026 Back-to-back bytes SHALL be strobed no earlier than 2 cycles after uart_busy_i falls.
REQ-027 uart_wr_o SHALL never be asserted while uart_busy_i is high at the IDLE decision edge.
REQ-028 Bytes SHALL be transmitted in push order with no duplication.

Reset
REQ-029 rst SHALL asynchronously clear pointers, level_o (0), overflow_o (0), uart_wr_o (0) and uart_dat_o (0x00), set empty_o to 1 and full_o to 0, and force the FSM to IDLE.
REQ-030 rst asserted mid-transfer SHALL discard all queued bytes; the first strobe after release SHALL only follow a new push.

Structure
REQ-031 Shared package uart_pkg SHALL hold the FSM state enumeration, the default DEPTH and the default BUSY_TIMEOUT.
REQ-032 The storage SHALL be sub-module uart_fifo (memory, pointers, level, full/empty); uart_tx_queue SHALL hold the feeder FSM, the timeout counter and the overflow flag.

Verification
REQ-033 Reset then push 0x55 with uart_busy_i low: uart_wr_o is high in cycle N+2, uart_dat_o is 0x55, and level_o returns to 0.
REQ-034 Push 0x01, 0x02, 0x03 back-to-back with a transmitter model holding busy for 20 cycles per byte: three strobes in order, each at least 2 cycles after busy falls.
REQ-035 Hold busy high and push DEPTH+1 bytes: full_o is 1, level_o is 16, overflow_o is 1, the extra byte is absent; ovf_clr_i then clears overflow_o.
REQ-036 Keep uart_busy_i at 0 after a strobe: the FSM returns to IDLE after 4 cycles and the next byte strobes.
REQ-037 Assert rst during WAIT_DONE with 5 bytes queued: all outputs take their reset values immediately, and no strobe occurs after release without a new push.
REQ-038 Push and pop in the same cycle with level 3: level_o stays 3 and pointer wrap-around is exercised over 40 bytes with data intact.
